// File: rtl/sram_bist_if.sv
// SRAM access bus between the BIST engine (master) and the SRAM controller (slave).
// One-cycle mem request; ready low while the controller works, read data valid when ready returns.
interface sram_bist_if #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 8
);
    logic                  mem;
    logic                  rw;
    logic                  ready;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data2ram;
    logic [DATA_WIDTH-1:0] data2fpga;

    modport master (output mem, rw, addr, data2ram, input ready, data2fpga);
    modport slave  (input mem, rw, addr, data2ram, output ready, data2fpga);
endinterface

// File: rtl/sram_bist.sv
// SRAM built-in self test: write/read-back of checkerboard, address and inverted-address patterns.
// Optional miscompare logging (err_addr / err_count) enabled by defining SRAM_BIST_ERRLOG_EN.
module sram_bist #(
    parameter int                    ADDR_WIDTH = 20,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] LAST_ADDR  = {ADDR_WIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [2:0]            pat_en,
    sram_bist_if.master           bus,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            result,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic [15:0]           err_count
);

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, CHECK, NEXT_PAT, DONE
    } state_t;

    state_t                state_r, state_nxt_s;
    logic                  mem_r, rw_r, busy_r, done_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] data2ram_r, rd_data_r;
    logic [2:0]            mask_r, result_r;
    logic [1:0]            pat_sel_r;
    logic [2:0]            first_pick_s, next_pick_s;
    logic                  accept_s, issue_wr_s, issue_rd_s, capture_s, check_s;
    logic                  addr_clr_s, addr_inc_s, pat_adv_s, miscmp_s;

    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [1:0] sel);
        logic [ADDR_WIDTH+DATA_WIDTH-1:0] ext;
        ext = {{DATA_WIDTH{1'b0}}, a};
        case (sel)
            2'd0:    pattern = a[0] ? {(DATA_WIDTH/2){2'b10}} : {(DATA_WIDTH/2){2'b01}};
            2'd1:    pattern = ext[DATA_WIDTH-1:0];
            2'd2:    pattern = ~ext[DATA_WIDTH-1:0];
            default: pattern = {DATA_WIDTH{1'b0}};
        endcase
    endfunction

    // Returns {found, index} of the lowest enabled pattern at or above 'from'.
    function automatic logic [2:0] pick_pat(input logic [2:0] mask, input logic [1:0] from);
        logic [2:0] elig;
        elig = mask & ~((3'b001 << from) - 3'b001);
        if (elig[0])      pick_pat = {1'b1, 2'd0};
        else if (elig[1]) pick_pat = {1'b1, 2'd1};
        else if (elig[2]) pick_pat = {1'b1, 2'd2};
        else              pick_pat = 3'b000;
    endfunction

    assign first_pick_s = pick_pat(pat_en, 2'd0);
    assign next_pick_s  = pick_pat(mask_r, pat_sel_r + 2'd1);
    assign miscmp_s     = check_s && (rd_data_r != pattern(addr_r, pat_sel_r));

    // Next-state and datapath strobes; ready is ignored while our own request is still on the bus.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        issue_wr_s  = 1'b0;
        issue_rd_s  = 1'b0;
        capture_s   = 1'b0;
        check_s     = 1'b0;
        addr_clr_s  = 1'b0;
        addr_inc_s  = 1'b0;
        pat_adv_s   = 1'b0;
        if (abort && state_r != IDLE && state_r != DONE) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        accept_s    = 1'b1;
                        state_nxt_s = (pat_en == 3'b000) ? DONE : WR_REQ;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                WR_REQ: begin
                    if (bus.ready) begin
                        issue_wr_s  = 1'b1;
                        state_nxt_s = WR_WAIT;
                    end else begin
                        state_nxt_s = WR_REQ;
                    end
                end
                WR_WAIT: begin
                    if (bus.ready && !mem_r) begin
                        if (addr_r == LAST_ADDR) begin
                            addr_clr_s  = 1'b1;
                            state_nxt_s = RD_REQ;
                        end else begin
                            addr_inc_s  = 1'b1;
                            state_nxt_s = WR_REQ;
                        end
                    end else begin
                        state_nxt_s = WR_WAIT;
                    end
                end
                RD_REQ: begin
                    if (bus.ready) begin
                        issue_rd_s  = 1'b1;
                        state_nxt_s = RD_WAIT;
                    end else begin
                        state_nxt_s = RD_REQ;
                    end
                end
                RD_WAIT: begin
                    if (bus.ready && !mem_r) begin
                        capture_s   = 1'b1;
                        state_nxt_s = CHECK;
                    end else begin
                        state_nxt_s = RD_WAIT;
                    end
                end
                CHECK: begin
                    check_s = 1'b1;
                    if (addr_r == LAST_ADDR) begin
                        state_nxt_s = NEXT_PAT;
                    end else begin
                        addr_inc_s  = 1'b1;
                        state_nxt_s = RD_REQ;
                    end
                end
                NEXT_PAT: begin
                    if (next_pick_s[2]) begin
                        pat_adv_s   = 1'b1;
                        addr_clr_s  = 1'b1;
                        state_nxt_s = WR_REQ;
                    end else begin
                        state_nxt_s = DONE;
                    end
                end
                DONE:    state_nxt_s = IDLE;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_nxt_s;
    end

    // Registered bus outputs, pattern bookkeeping and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r      <= 1'b0;
            rw_r       <= 1'b1;
            addr_r     <= {ADDR_WIDTH{1'b0}};
            data2ram_r <= {DATA_WIDTH{1'b0}};
            rd_data_r  <= {DATA_WIDTH{1'b0}};
            mask_r     <= 3'b000;
            pat_sel_r  <= 2'd0;
            result_r   <= 3'b000;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            mem_r  <= issue_wr_s | issue_rd_s;
            busy_r <= (state_nxt_s != IDLE) && (state_nxt_s != DONE);
            if (state_nxt_s == DONE) done_r <= 1'b1;
            else if (accept_s)       done_r <= 1'b0;
            if (accept_s) begin
                result_r  <= 3'b000;
                mask_r    <= pat_en;
                pat_sel_r <= first_pick_s[1:0];
            end else if (pat_adv_s) begin
                pat_sel_r <= next_pick_s[1:0];
            end
            if (accept_s || addr_clr_s) addr_r <= {ADDR_WIDTH{1'b0}};
            else if (addr_inc_s)        addr_r <= addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            if (issue_wr_s) begin
                rw_r       <= 1'b0;
                data2ram_r <= pattern(addr_r, pat_sel_r);
            end else if (issue_rd_s) begin
                rw_r <= 1'b1;
            end
            if (capture_s) rd_data_r <= bus.data2fpga;
            if (miscmp_s)  result_r[pat_sel_r] <= 1'b1;
        end
    end

`ifdef SRAM_BIST_ERRLOG_EN
    logic [ADDR_WIDTH-1:0] err_addr_r;
    logic [15:0]           err_count_r;

    // First-miscompare address and saturating miscompare count, cleared per run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_addr_r  <= {ADDR_WIDTH{1'b0}};
            err_count_r <= 16'd0;
        end else if (accept_s) begin
            err_addr_r  <= {ADDR_WIDTH{1'b0}};
            err_count_r <= 16'd0;
        end else if (miscmp_s) begin
            if (err_count_r == 16'd0)     err_addr_r  <= addr_r;
            if (err_count_r != 16'hFFFF) err_count_r <= err_count_r + 16'd1;
        end
    end

    assign err_addr  = err_addr_r;
    assign err_count = err_count_r;
`else
    assign err_addr  = {ADDR_WIDTH{1'b0}};
    assign err_count = 16'd0;
`endif

    assign bus.mem      = mem_r;
    assign bus.rw       = rw_r;
    assign bus.addr     = addr_r;
    assign bus.data2ram = data2ram_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign result       = result_r;

endmodule

// File: tb/tb_sram_bist.sv
// Directed self-checking bench for sram_bist (16x8 SRAM model, 2-cycle ready-low latency).
module tb_sram_bist;
`ifdef SRAM_BIST_ERRLOG_EN
    localparam bit ERRLOG = 1'b1;
`else
    localparam bit ERRLOG = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] pat_en = 3'b000;
    logic       busy, done;
    logic [2:0] result;
    logic [3:0] err_addr;
    logic [15:0] err_count;
    logic       stuck = 1'b0;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int viol   = 0;
    logic prev_mem = 1'b0;
    logic [1:0] lat;
    logic [7:0] mem_a [16];
    int wb, rb;

    sram_bist_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) sbus ();

    sram_bist #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .LAST_ADDR(4'd15)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pat_en(pat_en),
        .bus(sbus), .busy(busy), .done(done), .result(result),
        .err_addr(err_addr), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // SRAM model: ready low for two cycles after each request; optional bit-0 stuck-at-1 at addr 5.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbus.ready     <= 1'b1;
            sbus.data2fpga <= 8'h00;
            lat            <= 2'd0;
        end else if (sbus.mem) begin
            sbus.ready <= 1'b0;
            lat        <= 2'd2;
            if (!sbus.rw) mem_a[sbus.addr] <= sbus.data2ram | ((stuck && sbus.addr == 4'd5) ? 8'h01 : 8'h00);
            else          sbus.data2fpga   <= mem_a[sbus.addr];
        end else if (lat != 2'd0) begin
            lat <= lat - 2'd1;
            if (lat == 2'd1) sbus.ready <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (sbus.mem && !sbus.rw) wr_cnt <= wr_cnt + 1;
        if (sbus.mem && sbus.rw)  rd_cnt <= rd_cnt + 1;
    end

    // Protocol monitor: no request while ready is low, never two request cycles in a row.
    always @(negedge clk) begin
        if ((sbus.mem && !sbus.ready) || (sbus.mem && prev_mem)) viol <= viol + 1;
        prev_mem <= sbus.mem;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input logic [2:0] p);
        @(negedge clk);
        start  = 1'b1;
        pat_en = p;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem_a[i] = 8'h00;
        #12;
        check("rst_mem",   {31'd0, sbus.mem}, 32'd0);
        check("rst_rw",    {31'd0, sbus.rw}, 32'd1);
        check("rst_addr",  {28'd0, sbus.addr}, 32'd0);
        check("rst_wdata", {24'd0, sbus.data2ram}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_result", {29'd0, result}, 32'd0);
        check("rst_errcnt", {16'd0, err_count}, 32'd0);
        #11 rst_n = 1'b1;

        // Good memory, all three patterns.
        wb = wr_cnt; rb = rd_cnt;
        pulse_start(3'b111);
        check("t1_busy", {31'd0, busy}, 32'd1);
        wait_done("t1_done");
        check("t1_writes", wr_cnt - wb, 32'd48);
        check("t1_reads",  rd_cnt - rb, 32'd48);
        check("t1_result", {29'd0, result}, 32'd0);
        check("t1_errcnt", {16'd0, err_count}, 32'd0);
        check("t1_busy_end", {31'd0, busy}, 32'd0);
        check("t1_mem3",  {24'd0, mem_a[3]}, 32'h000000FC);
        check("t1_mem10", {24'd0, mem_a[10]}, 32'h000000F5);

        // Stuck-at-1 on bit 0 of address 5.
        stuck = 1'b1;
        pulse_start(3'b111);
        wait_done("t2_done");
        check("t2_result",  {29'd0, result}, 32'd5);
        check("t2_erraddr", {28'd0, err_addr}, ERRLOG ? 32'd5 : 32'd0);
        check("t2_errcnt",  {16'd0, err_count}, ERRLOG ? 32'd2 : 32'd0);

        // Address pattern only: stuck bit agrees with 0x05.
        wb = wr_cnt;
        pulse_start(3'b010);
        wait_done("t3_done");
        check("t3_result", {29'd0, result}, 32'd0);
        check("t3_writes", wr_cnt - wb, 32'd16);
        check("t3_mem9",  {24'd0, mem_a[9]}, 32'h00000009);
        check("t3_mem15", {24'd0, mem_a[15]}, 32'h0000000F);

        // Checkerboard only.
        pulse_start(3'b001);
        wait_done("t4_done");
        check("t4_result", {29'd0, result}, 32'd1);
        check("t4_errcnt", {16'd0, err_count}, ERRLOG ? 32'd1 : 32'd0);
        check("t4_mem4", {24'd0, mem_a[4]}, 32'h00000055);
        check("t4_mem5", {24'd0, mem_a[5]}, 32'h000000AB);

        // Empty mask completes without touching the SRAM.
        wb = wr_cnt; rb = rd_cnt;
        pulse_start(3'b000);
        @(negedge clk);
        check("t5_done",   {31'd0, done}, 32'd1);
        check("t5_result", {29'd0, result}, 32'd0);
        check("t5_access", (wr_cnt - wb) + (rd_cnt - rb), 32'd0);

        // Abort after the 10th write.
        stuck = 1'b0;
        wb = wr_cnt; rb = rd_cnt;
        pulse_start(3'b111);
        for (int n = 0; n < 500 && (wr_cnt - wb) < 10; n++) @(negedge clk);
        check("t6_tenth", wr_cnt - wb, 32'd10);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_done", {31'd0, done}, 32'd0);
        repeat (20) @(negedge clk);
        check("t6_writes", wr_cnt - wb, 32'd10);
        check("t6_reads",  rd_cnt - rb, 32'd0);

        // Reset while waiting for read data.
        wb = wr_cnt; rb = rd_cnt;
        pulse_start(3'b001);
        for (int n = 0; n < 500 && (rd_cnt - rb) < 3; n++) @(negedge clk);
        check("t7_reads3", rd_cnt - rb, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("t7_mem",  {31'd0, sbus.mem}, 32'd0);
        check("t7_rw",   {31'd0, sbus.rw}, 32'd1);
        check("t7_addr", {28'd0, sbus.addr}, 32'd0);
        check("t7_busy", {31'd0, busy}, 32'd0);
        check("t7_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("t7_writes", wr_cnt - wb, 32'd16);
        check("t7_reads",  rd_cnt - rb, 32'd3);
        check("t7_idle",   {31'd0, busy}, 32'd0);

        check("protocol", viol, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
